// File: rtl/axi_lite_rr_arbiter.sv
// Two-requester AXI-Lite arbiter sharing one manager port.
// Write (AW/W/B) and read (AR/R) paths are arbitrated independently, one outstanding
// transaction per direction, with round-robin priority per direction.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   _rq_{0,1}_*             requester-side AW/W/B/AR/R channels (valid/payload/ack)
//   _mst_*                  shared manager-side AW/W/B/AR/R channels
//   wr_busy, rd_busy        write/read FSM not idle
//   wr_owner, rd_owner      current or last granted requester per direction
module axi_lite_rr_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       _rq_0_aw_req_valid,
  input  logic [ADDR_W+2:0]          _rq_0_aw_req_0,
  output logic                       _rq_0_aw_req_ack,
  input  logic                       _rq_0_w_req_valid,
  input  logic [DATA_W+DATA_W/8-1:0] _rq_0_w_req_0,
  output logic                       _rq_0_w_req_ack,
  output logic                       _rq_0_b_resp_valid,
  output logic [1:0]                 _rq_0_b_resp_0,
  input  logic                       _rq_0_b_resp_ack,
  input  logic                       _rq_0_ar_req_valid,
  input  logic [ADDR_W+2:0]          _rq_0_ar_req_0,
  output logic                       _rq_0_ar_req_ack,
  output logic                       _rq_0_r_resp_valid,
  output logic [DATA_W+1:0]          _rq_0_r_resp_0,
  input  logic                       _rq_0_r_resp_ack,
  input  logic                       _rq_1_aw_req_valid,
  input  logic [ADDR_W+2:0]          _rq_1_aw_req_0,
  output logic                       _rq_1_aw_req_ack,
  input  logic                       _rq_1_w_req_valid,
  input  logic [DATA_W+DATA_W/8-1:0] _rq_1_w_req_0,
  output logic                       _rq_1_w_req_ack,
  output logic                       _rq_1_b_resp_valid,
  output logic [1:0]                 _rq_1_b_resp_0,
  input  logic                       _rq_1_b_resp_ack,
  input  logic                       _rq_1_ar_req_valid,
  input  logic [ADDR_W+2:0]          _rq_1_ar_req_0,
  output logic                       _rq_1_ar_req_ack,
  output logic                       _rq_1_r_resp_valid,
  output logic [DATA_W+1:0]          _rq_1_r_resp_0,
  input  logic                       _rq_1_r_resp_ack,
  output logic                       _mst_aw_req_valid,
  output logic [ADDR_W+2:0]          _mst_aw_req_0,
  input  logic                       _mst_aw_req_ack,
  output logic                       _mst_w_req_valid,
  output logic [DATA_W+DATA_W/8-1:0] _mst_w_req_0,
  input  logic                       _mst_w_req_ack,
  input  logic                       _mst_b_resp_valid,
  input  logic [1:0]                 _mst_b_resp_0,
  output logic                       _mst_b_resp_ack,
  output logic                       _mst_ar_req_valid,
  output logic [ADDR_W+2:0]          _mst_ar_req_0,
  input  logic                       _mst_ar_req_ack,
  input  logic                       _mst_r_resp_valid,
  input  logic [DATA_W+1:0]          _mst_r_resp_0,
  output logic                       _mst_r_resp_ack,
  output logic                       wr_busy,
  output logic                       rd_busy,
  output logic                       wr_owner,
  output logic                       rd_owner
);

  typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} wr_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RResp} rd_state_e;

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              wr_prio_q, wr_prio_d, wr_owner_q, wr_owner_d;
  logic              rd_prio_q, rd_prio_d, rd_owner_q, rd_owner_d;
  logic [ADDR_W+2:0] aw_q, aw_d, ar_q, ar_d;
  logic              wr_sel, rd_sel;

  // Write path
  always_comb begin
    wr_state_d          = wr_state_q;
    wr_prio_d           = wr_prio_q;
    wr_owner_d          = wr_owner_q;
    aw_d                = aw_q;
    _rq_0_aw_req_ack    = 1'b0;
    _rq_1_aw_req_ack    = 1'b0;
    _rq_0_w_req_ack     = 1'b0;
    _rq_1_w_req_ack     = 1'b0;
    _rq_0_b_resp_valid  = 1'b0;
    _rq_1_b_resp_valid  = 1'b0;
    _mst_aw_req_valid   = 1'b0;
    _mst_w_req_valid    = 1'b0;
    _mst_b_resp_ack     = 1'b0;
    // Lone requester wins; on contention the priority pointer decides.
    wr_sel = (_rq_0_aw_req_valid && _rq_1_aw_req_valid) ? wr_prio_q : _rq_1_aw_req_valid;
    unique case (wr_state_q)
      WIdle: begin
        if (_rq_0_aw_req_valid || _rq_1_aw_req_valid) begin
          _rq_0_aw_req_ack = ~wr_sel;
          _rq_1_aw_req_ack = wr_sel;
          aw_d             = wr_sel ? _rq_1_aw_req_0 : _rq_0_aw_req_0;
          wr_owner_d       = wr_sel;
          wr_state_d       = WAddr;
        end
      end
      WAddr: begin
        _mst_aw_req_valid = 1'b1;
        if (_mst_aw_req_ack) wr_state_d = WData;
      end
      WData: begin
        _mst_w_req_valid = wr_owner_q ? _rq_1_w_req_valid : _rq_0_w_req_valid;
        _rq_0_w_req_ack  = ~wr_owner_q & _mst_w_req_ack;
        _rq_1_w_req_ack  = wr_owner_q & _mst_w_req_ack;
        if (_mst_w_req_valid && _mst_w_req_ack) wr_state_d = WResp;
      end
      WResp: begin
        _rq_0_b_resp_valid = ~wr_owner_q & _mst_b_resp_valid;
        _rq_1_b_resp_valid = wr_owner_q & _mst_b_resp_valid;
        _mst_b_resp_ack    = wr_owner_q ? _rq_1_b_resp_ack : _rq_0_b_resp_ack;
        if (_mst_b_resp_valid && _mst_b_resp_ack) begin
          wr_prio_d  = ~wr_owner_q;
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  // Read path
  always_comb begin
    rd_state_d         = rd_state_q;
    rd_prio_d          = rd_prio_q;
    rd_owner_d         = rd_owner_q;
    ar_d               = ar_q;
    _rq_0_ar_req_ack   = 1'b0;
    _rq_1_ar_req_ack   = 1'b0;
    _rq_0_r_resp_valid = 1'b0;
    _rq_1_r_resp_valid = 1'b0;
    _mst_ar_req_valid  = 1'b0;
    _mst_r_resp_ack    = 1'b0;
    rd_sel = (_rq_0_ar_req_valid && _rq_1_ar_req_valid) ? rd_prio_q : _rq_1_ar_req_valid;
    unique case (rd_state_q)
      RIdle: begin
        if (_rq_0_ar_req_valid || _rq_1_ar_req_valid) begin
          _rq_0_ar_req_ack = ~rd_sel;
          _rq_1_ar_req_ack = rd_sel;
          ar_d             = rd_sel ? _rq_1_ar_req_0 : _rq_0_ar_req_0;
          rd_owner_d       = rd_sel;
          rd_state_d       = RAddr;
        end
      end
      RAddr: begin
        _mst_ar_req_valid = 1'b1;
        if (_mst_ar_req_ack) rd_state_d = RResp;
      end
      RResp: begin
        _rq_0_r_resp_valid = ~rd_owner_q & _mst_r_resp_valid;
        _rq_1_r_resp_valid = rd_owner_q & _mst_r_resp_valid;
        _mst_r_resp_ack    = rd_owner_q ? _rq_1_r_resp_ack : _rq_0_r_resp_ack;
        if (_mst_r_resp_valid && _mst_r_resp_ack) begin
          rd_prio_d  = ~rd_owner_q;
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WIdle;
      rd_state_q <= RIdle;
      wr_prio_q  <= 1'b0;
      rd_prio_q  <= 1'b0;
      wr_owner_q <= 1'b0;
      rd_owner_q <= 1'b0;
      aw_q       <= '0;
      ar_q       <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_prio_q  <= wr_prio_d;
      rd_prio_q  <= rd_prio_d;
      wr_owner_q <= wr_owner_d;
      rd_owner_q <= rd_owner_d;
      aw_q       <= aw_d;
      ar_q       <= ar_d;
    end
  end

  // Payloads are steered by owner; valids above qualify them.
  assign _mst_aw_req_0  = aw_q;
  assign _mst_ar_req_0  = ar_q;
  assign _mst_w_req_0   = wr_owner_q ? _rq_1_w_req_0 : _rq_0_w_req_0;
  assign _rq_0_b_resp_0 = _mst_b_resp_0;
  assign _rq_1_b_resp_0 = _mst_b_resp_0;
  assign _rq_0_r_resp_0 = _mst_r_resp_0;
  assign _rq_1_r_resp_0 = _mst_r_resp_0;

  assign wr_busy  = (wr_state_q != WIdle);
  assign rd_busy  = (rd_state_q != RIdle);
  assign wr_owner = wr_owner_q;
  assign rd_owner = rd_owner_q;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Self-checking bench for axi_lite_rr_arbiter: requester drivers, a simple slave model and a
// negedge monitor with a round-robin reference model and response scoreboards.
module tb_axi_lite_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic        rq_aw_valid [2], rq_aw_ack [2];
  logic [34:0] rq_aw_pay   [2];
  logic        rq_w_valid  [2], rq_w_ack  [2];
  logic [35:0] rq_w_pay    [2];
  logic        rq_b_valid  [2], rq_b_ack  [2];
  logic [1:0]  rq_b_pay    [2];
  logic        rq_ar_valid [2], rq_ar_ack [2];
  logic [34:0] rq_ar_pay   [2];
  logic        rq_r_valid  [2], rq_r_ack  [2];
  logic [33:0] rq_r_pay    [2];

  logic        mst_aw_valid, mst_aw_ack, mst_w_valid, mst_w_ack, mst_b_valid, mst_b_ack;
  logic        mst_ar_valid, mst_ar_ack, mst_r_valid, mst_r_ack;
  logic [34:0] mst_aw_pay, mst_ar_pay;
  logic [35:0] mst_w_pay;
  logic [1:0]  mst_b_pay;
  logic [33:0] mst_r_pay;
  logic        wr_busy, rd_busy, wr_owner, rd_owner;

  axi_lite_rr_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    ._rq_0_aw_req_valid (rq_aw_valid[0]), ._rq_0_aw_req_0 (rq_aw_pay[0]),
    ._rq_0_aw_req_ack   (rq_aw_ack[0]),
    ._rq_0_w_req_valid  (rq_w_valid[0]),  ._rq_0_w_req_0  (rq_w_pay[0]),
    ._rq_0_w_req_ack    (rq_w_ack[0]),
    ._rq_0_b_resp_valid (rq_b_valid[0]),  ._rq_0_b_resp_0 (rq_b_pay[0]),
    ._rq_0_b_resp_ack   (rq_b_ack[0]),
    ._rq_0_ar_req_valid (rq_ar_valid[0]), ._rq_0_ar_req_0 (rq_ar_pay[0]),
    ._rq_0_ar_req_ack   (rq_ar_ack[0]),
    ._rq_0_r_resp_valid (rq_r_valid[0]),  ._rq_0_r_resp_0 (rq_r_pay[0]),
    ._rq_0_r_resp_ack   (rq_r_ack[0]),
    ._rq_1_aw_req_valid (rq_aw_valid[1]), ._rq_1_aw_req_0 (rq_aw_pay[1]),
    ._rq_1_aw_req_ack   (rq_aw_ack[1]),
    ._rq_1_w_req_valid  (rq_w_valid[1]),  ._rq_1_w_req_0  (rq_w_pay[1]),
    ._rq_1_w_req_ack    (rq_w_ack[1]),
    ._rq_1_b_resp_valid (rq_b_valid[1]),  ._rq_1_b_resp_0 (rq_b_pay[1]),
    ._rq_1_b_resp_ack   (rq_b_ack[1]),
    ._rq_1_ar_req_valid (rq_ar_valid[1]), ._rq_1_ar_req_0 (rq_ar_pay[1]),
    ._rq_1_ar_req_ack   (rq_ar_ack[1]),
    ._rq_1_r_resp_valid (rq_r_valid[1]),  ._rq_1_r_resp_0 (rq_r_pay[1]),
    ._rq_1_r_resp_ack   (rq_r_ack[1]),
    ._mst_aw_req_valid  (mst_aw_valid),   ._mst_aw_req_0  (mst_aw_pay),
    ._mst_aw_req_ack    (mst_aw_ack),
    ._mst_w_req_valid   (mst_w_valid),    ._mst_w_req_0   (mst_w_pay),
    ._mst_w_req_ack     (mst_w_ack),
    ._mst_b_resp_valid  (mst_b_valid),    ._mst_b_resp_0  (mst_b_pay),
    ._mst_b_resp_ack    (mst_b_ack),
    ._mst_ar_req_valid  (mst_ar_valid),   ._mst_ar_req_0  (mst_ar_pay),
    ._mst_ar_req_ack    (mst_ar_ack),
    ._mst_r_resp_valid  (mst_r_valid),    ._mst_r_resp_0  (mst_r_pay),
    ._mst_r_resp_ack    (mst_r_ack),
    .wr_busy            (wr_busy),
    .rd_busy            (rd_busy),
    .wr_owner           (wr_owner),
    .rd_owner           (rd_owner)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboards: {owner, payload} for responses, raw payloads for manager-side requests.
  logic [34:0] exp_b_q[$];
  logic [34:0] exp_r_q[$];
  logic [34:0] mst_aw_exp_q[$];
  logic [35:0] mst_w_exp_q[$];
  logic [34:0] mst_ar_exp_q[$];

  // Reference model of arbitration state.
  logic wr_idle_m = 1'b1, rd_idle_m = 1'b1, wr_prio_m = 1'b0, rd_prio_m = 1'b0;
  logic wr_own_m = 1'b0, rd_own_m = 1'b0;
  logic [31:0] last_rdata [2];

  always @(negedge clk_i) begin : monitor
    logic [34:0] e;
    logic        sel;
    logic [1:0]  exp_ack;
    if (rst_i) begin
      wr_idle_m = 1'b1; rd_idle_m = 1'b1; wr_prio_m = 1'b0; rd_prio_m = 1'b0;
      wr_own_m = 1'b0;  rd_own_m = 1'b0;
      exp_b_q.delete(); exp_r_q.delete();
      mst_aw_exp_q.delete(); mst_w_exp_q.delete(); mst_ar_exp_q.delete();
    end else begin
      check_eq("wr_busy", wr_busy, !wr_idle_m);
      check_eq("rd_busy", rd_busy, !rd_idle_m);
      check_eq("wr_owner", wr_owner, wr_own_m);
      check_eq("rd_owner", rd_owner, rd_own_m);
      sel = (rq_aw_valid[0] && rq_aw_valid[1]) ? wr_prio_m : rq_aw_valid[1];
      exp_ack = (wr_idle_m && (rq_aw_valid[0] || rq_aw_valid[1])) ? (sel ? 2'b10 : 2'b01) : 2'b00;
      check_eq("wr_aw_ack", {rq_aw_ack[1], rq_aw_ack[0]}, exp_ack);
      sel = (rq_ar_valid[0] && rq_ar_valid[1]) ? rd_prio_m : rq_ar_valid[1];
      exp_ack = (rd_idle_m && (rq_ar_valid[0] || rq_ar_valid[1])) ? (sel ? 2'b10 : 2'b01) : 2'b00;
      check_eq("rd_ar_ack", {rq_ar_ack[1], rq_ar_ack[0]}, exp_ack);
      for (int n = 0; n < 2; n++) begin
        if (rq_aw_valid[n] && rq_aw_ack[n]) begin
          exp_b_q.push_back({1'(n), 32'b0, rq_aw_pay[n][9:8]});
          mst_aw_exp_q.push_back(rq_aw_pay[n]);
          wr_idle_m = 1'b0;
          wr_own_m  = 1'(n);
        end
        if (rq_ar_valid[n] && rq_ar_ack[n]) begin
          exp_r_q.push_back({1'(n), rq_ar_pay[n][9:8], 32'h12345678 ^ rq_ar_pay[n][31:0]});
          mst_ar_exp_q.push_back(rq_ar_pay[n]);
          rd_idle_m = 1'b0;
          rd_own_m  = 1'(n);
        end
        if (rq_w_valid[n] && rq_w_ack[n]) mst_w_exp_q.push_back(rq_w_pay[n]);
        if (rq_b_valid[n] && rq_b_ack[n]) begin
          if (exp_b_q.size() == 0) check_eq("b_spurious_valid", rq_b_valid[n], 1'b0);
          else begin
            e = exp_b_q.pop_front();
            check_eq("b_owner", n, e[34]);
            check_eq("b_resp", rq_b_pay[n], e[1:0]);
            wr_idle_m = 1'b1;
            wr_prio_m = ~1'(n);
          end
        end
        if (rq_r_valid[n] && rq_r_ack[n]) begin
          if (exp_r_q.size() == 0) check_eq("r_spurious_valid", rq_r_valid[n], 1'b0);
          else begin
            e = exp_r_q.pop_front();
            check_eq("r_owner", n, e[34]);
            check_eq("r_payload", rq_r_pay[n], e[33:0]);
            last_rdata[n] = rq_r_pay[n][31:0];
            rd_idle_m = 1'b1;
            rd_prio_m = ~1'(n);
          end
        end
      end
      if (mst_aw_valid && mst_aw_ack) begin
        if (mst_aw_exp_q.size() == 0) check_eq("mst_aw_spurious", mst_aw_valid, 1'b0);
        else check_eq("mst_aw_payload", mst_aw_pay, mst_aw_exp_q.pop_front());
      end
      if (mst_w_valid && mst_w_ack) begin
        if (mst_w_exp_q.size() == 0) check_eq("mst_w_spurious", mst_w_valid, 1'b0);
        else check_eq("mst_w_payload", mst_w_pay, mst_w_exp_q.pop_front());
      end
      if (mst_ar_valid && mst_ar_ack) begin
        if (mst_ar_exp_q.size() == 0) check_eq("mst_ar_spurious", mst_ar_valid, 1'b0);
        else check_eq("mst_ar_payload", mst_ar_pay, mst_ar_exp_q.pop_front());
      end
    end
  end

  // Slave: always ready for AW/W/AR; B after b_delay, R after r_delay extra cycles.
  int          b_delay = 0, r_delay = 0, b_cnt = 0, r_cnt = 0;
  logic        b_pend = 1'b0, r_pend = 1'b0;
  logic [31:0] slv_aw_addr = '0, slv_ar_addr = '0;
  logic        s_rst, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;

  always begin : slave
    @(negedge clk_i);
    s_rst   = rst_i;
    s_w_hs  = mst_w_valid && mst_w_ack;
    s_b_hs  = mst_b_valid && mst_b_ack;
    s_ar_hs = mst_ar_valid && mst_ar_ack;
    s_r_hs  = mst_r_valid && mst_r_ack;
    if (mst_aw_valid && mst_aw_ack) slv_aw_addr = mst_aw_pay[31:0];
    if (s_ar_hs) slv_ar_addr = mst_ar_pay[31:0];
    @(posedge clk_i);
    #1;
    if (s_rst) begin
      mst_b_valid = 1'b0; mst_r_valid = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    end else begin
      if (s_b_hs) mst_b_valid = 1'b0;
      if (s_r_hs) mst_r_valid = 1'b0;
      if (s_w_hs) begin b_pend = 1'b1; b_cnt = b_delay; end
      if (s_ar_hs) begin r_pend = 1'b1; r_cnt = r_delay; end
      if (b_pend) begin
        if (b_cnt == 0) begin
          mst_b_valid = 1'b1; mst_b_pay = slv_aw_addr[9:8]; b_pend = 1'b0;
        end else b_cnt--;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          mst_r_valid = 1'b1; mst_r_pay = {slv_ar_addr[9:8], 32'h12345678 ^ slv_ar_addr};
          r_pend = 1'b0;
        end else r_cnt--;
      end
    end
  end

  // Full write from requester n; waits = cycles AW valid was held without ack.
  task automatic rq_write(input int n, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int waits);
    int cnt;
    rq_aw_pay[n]   = {3'b010, addr};
    rq_aw_valid[n] = 1'b1;
    waits = 0;
    @(negedge clk_i);
    while (!rq_aw_ack[n] && waits < 200) begin waits++; @(negedge clk_i); end
    if (!rq_aw_ack[n]) begin
      check_eq("aw_timeout", rq_aw_ack[n], 1'b1);
      @(posedge clk_i); #1; rq_aw_valid[n] = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    rq_aw_valid[n] = 1'b0;
    rq_w_pay[n]    = {strb, data};
    rq_w_valid[n]  = 1'b1;
    @(negedge clk_i);
    check_eq("mst_aw_latency", mst_aw_valid, 1'b1);
    cnt = 0;
    while (!rq_w_ack[n] && cnt < 200) begin cnt++; @(negedge clk_i); end
    if (!rq_w_ack[n]) check_eq("w_timeout", rq_w_ack[n], 1'b1);
    @(posedge clk_i); #1;
    rq_w_valid[n] = 1'b0;
    cnt = 0;
    @(negedge clk_i);
    while (!rq_b_valid[n] && cnt < 200) begin cnt++; @(negedge clk_i); end
    if (!rq_b_valid[n]) check_eq("b_timeout", rq_b_valid[n], 1'b1);
    @(posedge clk_i); #1;
  endtask

  task automatic rq_read(input int n, input logic [31:0] addr, output int waits);
    int cnt;
    rq_ar_pay[n]   = {3'b001, addr};
    rq_ar_valid[n] = 1'b1;
    waits = 0;
    @(negedge clk_i);
    while (!rq_ar_ack[n] && waits < 200) begin waits++; @(negedge clk_i); end
    if (!rq_ar_ack[n]) begin
      check_eq("ar_timeout", rq_ar_ack[n], 1'b1);
      @(posedge clk_i); #1; rq_ar_valid[n] = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    rq_ar_valid[n] = 1'b0;
    @(negedge clk_i);
    check_eq("mst_ar_latency", mst_ar_valid, 1'b1);
    cnt = 0;
    while (!rq_r_valid[n] && cnt < 200) begin cnt++; @(negedge clk_i); end
    if (!rq_r_valid[n]) check_eq("r_timeout", rq_r_valid[n], 1'b1);
    @(posedge clk_i); #1;
  endtask

  function automatic logic [15:0] idle_outputs();
    return {mst_aw_valid, mst_w_valid, mst_ar_valid, mst_b_ack, mst_r_ack,
            rq_aw_ack[0], rq_aw_ack[1], rq_w_ack[0], rq_w_ack[1], rq_ar_ack[0], rq_ar_ack[1],
            rq_b_valid[0], rq_b_valid[1], rq_r_valid[0], rq_r_valid[1], wr_busy | rd_busy};
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("reset_state", {idle_outputs(), wr_owner, rd_owner}, 18'd0);
    @(posedge clk_i); #1;
  endtask

  int w0, w1, wa, wb;

  initial begin
    for (int n = 0; n < 2; n++) begin
      rq_aw_valid[n] = 1'b0; rq_w_valid[n] = 1'b0; rq_ar_valid[n] = 1'b0;
      rq_aw_pay[n] = '0; rq_w_pay[n] = '0; rq_ar_pay[n] = '0;
      rq_b_ack[n] = 1'b1; rq_r_ack[n] = 1'b1;
    end
    mst_aw_ack = 1'b1; mst_w_ack = 1'b1; mst_ar_ack = 1'b1;
    mst_b_valid = 1'b0; mst_r_valid = 1'b0; mst_b_pay = '0; mst_r_pay = '0;

    do_reset();

    // Single write from rq0, granted in the cycle AW valid rises.
    rq_write(0, 32'h10, 32'hDEADBEEF, 4'hF, w0);
    check_eq("aw_ack_cycle0", w0, 0);

    // Contention: 4 writes each; rq1 first since rq0 just completed, then alternating.
    fork
      begin for (int i = 0; i < 4; i++) rq_write(0, 32'h100 * i, $urandom, 4'h3, wa); end
      begin for (int i = 0; i < 4; i++) rq_write(1, 32'h104 * i + 32'h8, $urandom, 4'hC, wb); end
    join

    do_reset();

    // Simultaneous reads: rq0 first, rq1 the cycle after rq0's R handshake.
    fork
      rq_read(0, 32'h100, w0);
      rq_read(1, 32'h204, w1);
    join
    check_eq("rd_first_grant_wait", w0, 0);
    check_eq("rd_second_grant_wait", w1, 3);

    // Concurrent write (rq1) and read (rq0).
    r_delay = 3;
    fork
      rq_write(1, 32'h40, 32'hCAFEF00D, 4'hF, wa);
      rq_read(0, 32'h0, wb);
      begin
        tick();
        tick();
        @(negedge clk_i);
        check_eq("both_busy", {wr_busy, rd_busy}, 2'b11);
      end
    join
    check_eq("r_data_rq0", last_rdata[0], 32'h12345678);
    r_delay = 0;

    // Slow B: a second AW from rq0 waits through the whole response gap.
    b_delay = 5;
    fork
      rq_write(0, 32'h300, 32'h0BADF00D, 4'hF, wa);
      begin
        repeat (4) tick();
        rq_write(0, 32'h204, 32'h11223344, 4'h1, wb);
      end
    join
    check_eq("aw_wait_cycles", wb, 5);
    b_delay = 0;

    // Reset while in the data phase.
    rq_aw_pay[0]   = {3'b000, 32'h80};
    rq_aw_valid[0] = 1'b1;
    tick();
    rq_aw_valid[0] = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("reset_in_wdata_outputs", idle_outputs(), 16'd0);
    check_eq("reset_in_wdata_busy", wr_busy, 1'b0);
    @(posedge clk_i); #1;
    fork
      rq_write(0, 32'h500, 32'h55AA55AA, 4'hF, wa);
      rq_write(1, 32'h600, 32'hAA55AA55, 4'hF, wb);
      begin
        @(negedge clk_i);
        check_eq("post_reset_grant", {rq_aw_ack[1], rq_aw_ack[0]}, 2'b01);
      end
    join

    repeat (3) tick();
    check_eq("sb_empty", exp_b_q.size() + exp_r_q.size() + mst_aw_exp_q.size() +
             mst_w_exp_q.size() + mst_ar_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
